// File: rtl/isp_frame_ctrl_pkg.sv
// ============================================================================
// isp_frame_ctrl_pkg : register map, CTRL layout and FSM encoding for the frame controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package isp_frame_ctrl_pkg;

    localparam logic [1:0] c_reg_ctrl      = 2'd0;
    localparam logic [1:0] c_reg_status    = 2'd1;
    localparam logic [1:0] c_reg_frame_cnt = 2'd2;
    localparam logic [1:0] c_reg_size      = 2'd3;

    localparam int c_status_busy_bit = 0;
    localparam int c_status_err_bit  = 1;
    localparam int c_status_irq_bit  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VSYNC  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // Field order matches CTRL bits [3] bypass, [2:1] bayer, [0] enable.
    typedef struct packed {
        logic       bypass;
        logic [1:0] bayer;
        logic       enable;
    } ctrl_t;

    function automatic ctrl_t ctrl_from_word(input logic [31:0] i_word);
        return ctrl_t'(i_word[3:0]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/isp_timing_cnt.sv
// ============================================================================
// isp_timing_cnt : vsync/href edge detectors, saturating pixel/line counters, line_bad
// Revision: 1.0
// ============================================================================
`default_nettype none

module isp_timing_cnt #(
    parameter int WIDTH = 1280,
    parameter int CNT_W = 16
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             i_href,
    input  logic             i_vsync,
    input  logic             i_clr,
    input  logic             i_cnt_en,
    output logic             o_vs_rise,
    output logic             o_vs_fall,
    output logic [CNT_W-1:0] o_line_cnt,
    output logic [CNT_W-1:0] o_last_px,
    output logic             o_line_bad
);

    logic             r_vsync_q;
    logic             r_href_q;
    logic [CNT_W-1:0] r_px_cnt;
    logic [CNT_W-1:0] r_line_cnt;
    logic [CNT_W-1:0] r_last_px;
    logic             r_line_bad;
    logic             w_href_fall;

    assign o_vs_rise   =  i_vsync & ~r_vsync_q;
    assign o_vs_fall   = ~i_vsync &  r_vsync_q;
    assign w_href_fall = ~i_href  &  r_href_q;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_q  <= 1'b0;
            r_href_q   <= 1'b0;
            r_px_cnt   <= '0;
            r_line_cnt <= '0;
            r_last_px  <= '0;
            r_line_bad <= 1'b0;
        end else begin
            r_vsync_q <= i_vsync;
            r_href_q  <= i_href;
            if (i_clr) begin
                r_px_cnt   <= '0;
                r_line_cnt <= '0;
                r_last_px  <= '0;
                r_line_bad <= 1'b0;
            end else if (i_cnt_en) begin
                // Counters stick at all-ones so an overlong line or frame still reads as bad.
                if (w_href_fall) begin
                    if (r_line_cnt != '1) begin
                        r_line_cnt <= r_line_cnt + 1'b1;
                    end
                    r_last_px <= r_px_cnt;
                    r_px_cnt  <= '0;
                    if (r_px_cnt != CNT_W'(WIDTH)) begin
                        r_line_bad <= 1'b1;
                    end
                end else if (i_href && (r_px_cnt != '1)) begin
                    r_px_cnt <= r_px_cnt + 1'b1;
                end
            end
        end
    end

    assign o_line_cnt = r_line_cnt;
    assign o_last_px  = r_last_px;
    assign o_line_bad = r_line_bad;

endmodule

`default_nettype wire

// File: rtl/isp_frame_ctrl.sv
// ============================================================================
// isp_frame_ctrl : frame FSM, Avalon-MM register file and frame-boundary config commit
// Revision: 1.0
// ============================================================================
`default_nettype none

module isp_frame_ctrl
    import isp_frame_ctrl_pkg::*;
#(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960,
    parameter int CNT_W  = 16
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        i_href,
    input  logic        i_vsync,
    input  logic [1:0]  i_avs_address,
    input  logic        i_avs_write,
    input  logic [31:0] i_avs_writedata,
    input  logic        i_avs_read,
    output logic [31:0] o_avs_readdata,
    output logic        o_cfg_enable,
    output logic [1:0]  o_cfg_bayer,
    output logic        o_cfg_bypass,
    output logic        o_frame_start,
    output logic        o_irq
);

    state_t           r_state;
    state_t           w_next;
    ctrl_t            r_pend;
    ctrl_t            r_cfg;
    logic             r_frame_start;
    logic             r_err;
    logic             r_irq;
    logic [31:0]      r_frame_cnt;
    logic [31:0]      r_size;
    logic [31:0]      r_rdata;
    logic [31:0]      w_rd_mux;

    logic             w_vs_rise;
    logic             w_vs_fall;
    logic [CNT_W-1:0] w_line_cnt;
    logic [CNT_W-1:0] w_last_px;
    logic             w_line_bad;
    logic             w_clr;
    logic             w_cnt_en;
    logic             w_frame_end;
    logic             w_fs;
    logic             w_wr_ctrl;
    logic             w_w1c;
    logic             w_frame_bad;
    logic             w_unused_wdata;

    isp_timing_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_timing (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .i_href     (i_href),
        .i_vsync    (i_vsync),
        .i_clr      (w_clr),
        .i_cnt_en   (w_cnt_en),
        .o_vs_rise  (w_vs_rise),
        .o_vs_fall  (w_vs_fall),
        .o_line_cnt (w_line_cnt),
        .o_last_px  (w_last_px),
        .o_line_bad (w_line_bad)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The next-state decision uses the pending enable because that is what vs_rise commits.
    always_comb begin
        w_next      = r_state;
        w_clr       = 1'b0;
        w_cnt_en    = 1'b0;
        w_frame_end = 1'b0;
        w_fs        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_vs_rise && r_pend.enable) begin
                    w_next = ST_VSYNC;
                end
            end
            ST_VSYNC: begin
                w_clr = 1'b1;
                if (w_vs_fall) begin
                    w_fs   = 1'b1;
                    w_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                w_cnt_en = 1'b1;
                if (w_vs_rise) begin
                    w_frame_end = 1'b1;
                    w_next      = r_pend.enable ? ST_VSYNC : ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign w_wr_ctrl      = i_avs_write && (i_avs_address == c_reg_ctrl);
    assign w_w1c          = i_avs_write && (i_avs_address == c_reg_status);
    assign w_frame_bad    = w_line_bad || (w_line_cnt != CNT_W'(HEIGHT));
    assign w_unused_wdata = ^i_avs_writedata[31:4];

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend        <= '0;
            r_cfg         <= '0;
            r_frame_start <= 1'b0;
            r_err         <= 1'b0;
            r_irq         <= 1'b0;
            r_frame_cnt   <= '0;
            r_size        <= '0;
        end else begin
            r_frame_start <= w_fs;
            if (w_wr_ctrl) begin
                r_pend <= ctrl_from_word(i_avs_writedata);
            end
            // r_pend is the pre-write value here, so a same-cycle CTRL write waits a frame.
            if (w_vs_rise) begin
                r_cfg <= r_pend;
            end
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
                r_size      <= {16'(w_line_cnt), 16'(w_last_px)};
            end
            if (w_frame_end && w_frame_bad) begin
                r_err <= 1'b1;
            end else if (w_w1c && i_avs_writedata[c_status_err_bit]) begin
                r_err <= 1'b0;
            end
            if (w_frame_end) begin
                r_irq <= 1'b1;
            end else if (w_w1c && i_avs_writedata[c_status_irq_bit]) begin
                r_irq <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (i_avs_address)
            c_reg_ctrl:      w_rd_mux = {28'd0, r_pend};
            c_reg_status: begin
                w_rd_mux[c_status_busy_bit] = (r_state == ST_ACTIVE);
                w_rd_mux[c_status_err_bit]  = r_err;
                w_rd_mux[c_status_irq_bit]  = r_irq;
            end
            c_reg_frame_cnt: w_rd_mux = r_frame_cnt;
            c_reg_size:      w_rd_mux = r_size;
            default:         w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= i_avs_read ? w_rd_mux : 32'd0;
        end
    end

    assign o_avs_readdata = r_rdata;
    assign o_cfg_enable   = r_cfg.enable;
    assign o_cfg_bayer    = r_cfg.bayer;
    assign o_cfg_bypass   = r_cfg.bypass;
    assign o_frame_start  = r_frame_start;
    assign o_irq          = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_isp_frame_ctrl.sv
// ============================================================================
// tb_isp_frame_ctrl : directed scenario bench for isp_frame_ctrl with a 4x3 frame geometry
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_isp_frame_ctrl;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        href;
    logic        vsync;
    logic [1:0]  addr;
    logic        write;
    logic [31:0] wdata;
    logic        read;
    logic [31:0] rdata;
    logic        cfg_enable;
    logic [1:0]  cfg_bayer;
    logic        cfg_bypass;
    logic        frame_start;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    int fs_cnt   = 0;

    isp_frame_ctrl #(
        .WIDTH  (4),
        .HEIGHT (3),
        .CNT_W  (16)
    ) dut (
        .pclk            (pclk),
        .rst_n           (rst_n),
        .i_href          (href),
        .i_vsync         (vsync),
        .i_avs_address   (addr),
        .i_avs_write     (write),
        .i_avs_writedata (wdata),
        .i_avs_read      (read),
        .o_avs_readdata  (rdata),
        .o_cfg_enable    (cfg_enable),
        .o_cfg_bayer     (cfg_bayer),
        .o_cfg_bypass    (cfg_bypass),
        .o_frame_start   (frame_start),
        .o_irq           (irq)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        if (frame_start) fs_cnt++;
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a; read = 1'b1;
        tick();
        read = 1'b0;
        d = rdata;
    endtask

    task automatic vs_start();
        vsync = 1'b1;
        tick();
    endtask

    task automatic vs_end();
        tick(); tick();
        vsync = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic do_line(input int npx);
        href = 1'b1;
        repeat (npx) tick();
        href = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0; href = 0; vsync = 0; addr = 0; write = 0; wdata = 0; read = 0;
        #12;
        n_checks++;
        if ({rdata, cfg_enable, cfg_bayer, cfg_bypass, frame_start, irq} !== 38'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0",
                {rdata, cfg_enable, cfg_bayer, cfg_bypass, frame_start, irq});
        end
        #1 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), d);
            n_checks++;
            if (d !== 32'd0) begin
                n_fail++; $display("FAIL reset_reg%0d: got %h expected 0", i, d);
            end
        end
    endtask

    task automatic test_basic_frames();
        logic [31:0] d;
        int fs0;
        wr(2'd0, 32'h7);
        n_checks++;
        if (cfg_enable !== 1'b0) begin
            n_fail++; $display("FAIL pending_only: cfg_enable got %b expected 0", cfg_enable);
        end
        vs_start();
        n_checks++;
        if ({cfg_enable, cfg_bayer, cfg_bypass} !== 4'b1110) begin
            n_fail++; $display("FAIL first_commit: cfg got %b expected 1110", {cfg_enable, cfg_bayer, cfg_bypass});
        end
        fs0 = fs_cnt;
        vs_end();
        n_checks++;
        if (fs_cnt !== fs0 + 1) begin
            n_fail++; $display("FAIL frame_start_pulse: count got %0d expected %0d", fs_cnt, fs0 + 1);
        end
        rd(2'd1, d);
        n_checks++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL busy_active: status got %h expected 1", d);
        end
        repeat (3) do_line(4);
        vs_start();
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_frame_end: got %b expected 1", irq);
        end
        rd(2'd1, d);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++; $display("FAIL status_good_frame: got %h expected 4", d);
        end
        rd(2'd2, d);
        n_checks++;
        if (d !== 32'd1) begin
            n_fail++; $display("FAIL frame_cnt_1: got %h expected 1", d);
        end
        rd(2'd3, d);
        n_checks++;
        if (d !== 32'h0003_0004) begin
            n_fail++; $display("FAIL size_4x3: got %h expected 00030004", d);
        end
        tick();
        n_checks++;
        if (rdata !== 32'd0) begin
            n_fail++; $display("FAIL readdata_idle: got %h expected 0", rdata);
        end
        vs_end();
    endtask

    task automatic test_frame_errors();
        logic [31:0] d;
        do_line(4); do_line(3); do_line(4);
        vs_start();
        rd(2'd1, d);
        n_checks++;
        if (d !== 32'h6) begin
            n_fail++; $display("FAIL err_short_line: status got %h expected 6", d);
        end
        rd(2'd2, d);
        n_checks++;
        if (d !== 32'd2) begin
            n_fail++; $display("FAIL frame_cnt_2: got %h expected 2", d);
        end
        wr(2'd1, 32'h6);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_w1c: got %b expected 0", irq);
        end
        rd(2'd1, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL status_after_w1c: got %h expected 0", d);
        end
        vs_end();
        do_line(4); do_line(4);
        vs_start();
        rd(2'd1, d);
        n_checks++;
        if (d !== 32'h6) begin
            n_fail++; $display("FAIL err_two_lines: status got %h expected 6", d);
        end
        rd(2'd3, d);
        n_checks++;
        if (d !== 32'h0002_0004) begin
            n_fail++; $display("FAIL size_4x2: got %h expected 00020004", d);
        end
        wr(2'd1, 32'h6);
        vs_end();
    endtask

    task automatic test_same_cycle_commit();
        logic [31:0] d;
        repeat (3) do_line(4);
        vsync = 1'b1; addr = 2'd0; wdata = 32'h3; write = 1'b1;
        tick();
        write = 1'b0;
        n_checks++;
        if ({cfg_enable, cfg_bayer} !== 3'b111) begin
            n_fail++; $display("FAIL same_cycle_hold: cfg got %b expected 111", {cfg_enable, cfg_bayer});
        end
        rd(2'd0, d);
        n_checks++;
        if (d !== 32'h3) begin
            n_fail++; $display("FAIL pending_readback: got %h expected 3", d);
        end
        vs_end();
        repeat (3) do_line(4);
        vs_start();
        n_checks++;
        if ({cfg_enable, cfg_bayer} !== 3'b101) begin
            n_fail++; $display("FAIL next_frame_commit: cfg got %b expected 101", {cfg_enable, cfg_bayer});
        end
        rd(2'd2, d);
        n_checks++;
        if (d !== 32'd5) begin
            n_fail++; $display("FAIL frame_cnt_5: got %h expected 5", d);
        end
        wr(2'd1, 32'h6);
        vs_end();
    endtask

    task automatic test_disable();
        logic [31:0] d;
        int fs0;
        do_line(4);
        wr(2'd0, 32'h0);
        do_line(4); do_line(4);
        vs_start();
        n_checks++;
        if (cfg_enable !== 1'b0) begin
            n_fail++; $display("FAIL disable_commit: cfg_enable got %b expected 0", cfg_enable);
        end
        rd(2'd2, d);
        n_checks++;
        if (d !== 32'd6) begin
            n_fail++; $display("FAIL frame_cnt_6: got %h expected 6", d);
        end
        fs0 = fs_cnt;
        vs_end();
        repeat (3) do_line(4);
        vs_start();
        vs_end();
        n_checks++;
        if (fs_cnt !== fs0) begin
            n_fail++; $display("FAIL idle_no_frame_start: count got %0d expected %0d", fs_cnt, fs0);
        end
        rd(2'd2, d);
        n_checks++;
        if (d !== 32'd6) begin
            n_fail++; $display("FAIL idle_not_counted: got %h expected 6", d);
        end
        rd(2'd1, d);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++; $display("FAIL idle_status: got %h expected 4", d);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        wr(2'd0, 32'h1);
        vs_start();
        vs_end();
        do_line(4);
        href = 1'b1;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rdata, cfg_enable, cfg_bayer, cfg_bypass, frame_start, irq} !== 38'd0) begin
            n_fail++; $display("FAIL async_reset_outputs: got %h expected 0",
                {rdata, cfg_enable, cfg_bayer, cfg_bypass, frame_start, irq});
        end
        href = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        rd(2'd2, d);
        n_checks++;
        if (d !== 32'd0) begin
            n_fail++; $display("FAIL frame_cnt_after_reset: got %h expected 0", d);
        end
        wr(2'd0, 32'h1);
        vs_start();
        vs_end();
        repeat (3) do_line(4);
        vs_start();
        rd(2'd2, d);
        n_checks++;
        if (d !== 32'd1) begin
            n_fail++; $display("FAIL frame_cnt_restart: got %h expected 1", d);
        end
        rd(2'd1, d);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++; $display("FAIL status_restart: got %h expected 4", d);
        end
        wr(2'd1, 32'h6);
        vs_end();
    endtask

    task automatic test_saturation();
        logic [31:0] d;
        href = 1'b1;
        repeat (70000) tick();
        href = 1'b0;
        tick(); tick();
        vs_start();
        rd(2'd3, d);
        n_checks++;
        if (d !== 32'h0001_FFFF) begin
            n_fail++; $display("FAIL px_saturate: size got %h expected 0001ffff", d);
        end
        rd(2'd1, d);
        n_checks++;
        if (d !== 32'h6) begin
            n_fail++; $display("FAIL saturate_err: status got %h expected 6", d);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frames();
        test_frame_errors();
        test_same_cycle_commit();
        test_disable();
        test_reset_mid_frame();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
